// File: rtl/udp_buf_scheduler.sv
// Owns write port A of the 512x32 UDP packet RAM: power-up preload, rx pass-through, tx scheduling.
// States: PRELOAD | IDLE | TX_WAIT. Define UDP_SCHED_DROP_CNT_EN to add the drop_cnt output.
module udp_buf_scheduler #(
    parameter int unsigned PRELOAD_WORDS = 5,
    parameter int unsigned PERIOD_CYCLES = 25000000,
    parameter logic [15:0] DEF_DATA_LEN  = 16'd28,
    parameter logic [15:0] DEF_TOTAL_LEN = 16'd48
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [3:0]  pl_idx,
    input  logic [31:0] pl_data,
    input  logic        rx_wr_en,
    input  logic [8:0]  rx_wr_addr,
    input  logic [31:0] rx_wr_data,
    input  logic        rx_frame_done,
    input  logic [15:0] rx_data_length,
    input  logic [15:0] rx_total_length,
    output logic        ram_we,
    output logic [8:0]  ram_addr,
    output logic [31:0] ram_din,
    output logic        tx_start,
    input  logic        tx_done,
    output logic [15:0] tx_data_length,
    output logic [15:0] tx_total_length,
    output logic        have_rx
`ifdef UDP_SCHED_DROP_CNT_EN
    ,
    output logic [15:0] drop_cnt
`endif
);

    typedef enum logic [1:0] {S_PRELOAD, S_IDLE, S_TX_WAIT} state_t;

    localparam int          TW         = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(PERIOD_CYCLES - 1);
    localparam logic [3:0]  PL_LAST    = 4'(PRELOAD_WORDS - 1);

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_pl_idx, w_pl_idx_nxt;
    logic          r_ram_we, w_ram_we_nxt;
    logic [8:0]    r_ram_addr, w_ram_addr_nxt;
    logic [31:0]   r_ram_din, w_ram_din_nxt;
    logic          r_tx_start, w_tx_start_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic [15:0]   r_data_len, w_data_len_nxt;
    logic [15:0]   r_total_len, w_total_len_nxt;
    logic          r_have_rx, w_have_rx_nxt;
    logic          r_rx_active, w_rx_active_nxt;
    logic          r_dropped, w_dropped_nxt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_PRELOAD;
            r_pl_idx    <= '0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_din   <= '0;
            r_tx_start  <= 1'b0;
            r_timer     <= '0;
            r_data_len  <= DEF_DATA_LEN;
            r_total_len <= DEF_TOTAL_LEN;
            r_have_rx   <= 1'b0;
            r_rx_active <= 1'b0;
            r_dropped   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pl_idx    <= w_pl_idx_nxt;
            r_ram_we    <= w_ram_we_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_din   <= w_ram_din_nxt;
            r_tx_start  <= w_tx_start_nxt;
            r_timer     <= w_timer_nxt;
            r_data_len  <= w_data_len_nxt;
            r_total_len <= w_total_len_nxt;
            r_have_rx   <= w_have_rx_nxt;
            r_rx_active <= w_rx_active_nxt;
            r_dropped   <= w_dropped_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pl_idx_nxt    = r_pl_idx;
        w_ram_we_nxt    = 1'b0;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_din_nxt   = r_ram_din;
        w_tx_start_nxt  = 1'b0;
        w_timer_nxt     = '0;
        w_data_len_nxt  = r_data_len;
        w_total_len_nxt = r_total_len;
        w_have_rx_nxt   = r_have_rx;
        w_rx_active_nxt = rx_frame_done ? 1'b0 : (rx_wr_en ? 1'b1 : r_rx_active);
        // A word blocked while locked poisons the rest of its frame until the frame ends.
        w_dropped_nxt   = rx_frame_done ? 1'b0
                        : ((r_state == S_TX_WAIT && rx_wr_en) ? 1'b1 : r_dropped);
        case (r_state)
            S_PRELOAD: begin
                w_ram_we_nxt   = 1'b1;
                w_ram_addr_nxt = {5'd0, r_pl_idx};
                w_ram_din_nxt  = pl_data;
                if (r_pl_idx == PL_LAST) begin
                    w_pl_idx_nxt = '0;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_pl_idx_nxt = r_pl_idx + 4'd1;
                end
            end
            S_IDLE: begin
                w_ram_we_nxt   = rx_wr_en;
                w_ram_addr_nxt = rx_wr_addr;
                w_ram_din_nxt  = rx_wr_data;
                // A completed frame outranks a coinciding periodic expiry.
                if (rx_frame_done && !r_dropped) begin
                    w_data_len_nxt  = rx_data_length;
                    w_total_len_nxt = rx_total_length;
                    w_have_rx_nxt   = 1'b1;
                    w_tx_start_nxt  = 1'b1;
                    w_state_nxt     = S_TX_WAIT;
                end else if (!r_rx_active && r_timer == TIMER_LAST) begin
                    w_tx_start_nxt  = 1'b1;
                    w_state_nxt     = S_TX_WAIT;
                end else if (!r_rx_active) begin
                    w_timer_nxt     = r_timer + TW'(1);
                end else begin
                    w_timer_nxt     = r_timer;
                end
            end
            S_TX_WAIT: begin
                if (tx_done) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_PRELOAD;
        endcase
    end

`ifdef UDP_SCHED_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_drop_cnt <= '0;
        end else if (r_state == S_TX_WAIT && rx_wr_en && r_drop_cnt != 16'hFFFF) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign pl_idx          = r_pl_idx;
    assign ram_we          = r_ram_we;
    assign ram_addr        = r_ram_addr;
    assign ram_din         = r_ram_din;
    assign tx_start        = r_tx_start;
    assign tx_data_length  = r_data_len;
    assign tx_total_length = r_total_len;
    assign have_rx         = r_have_rx;

endmodule
